// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the MIPS-style core.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port: index mux, optional same-cycle write bypass,
// and the hardwired-zero override for register 0.
module reg_file_rd_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Zero override is applied last so that neither storage nor bypass can
    // ever make register 0 read non-zero.
    always_comb begin
        rd_data = regs[rd_idx];
        if ((BYPASS != 0) && wr_en && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end
        if (rd_idx == ADDR_W'(ZERO_REG)) begin
            rd_data = '0;
        end
    end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// General-purpose register file: 2**ADDR_W registers, two combinational
// read ports (rs, rt), one write port committed on the rising clock edge.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_idx,
    input  logic [ADDR_W-1:0] rt_idx,
    input  logic [ADDR_W-1:0] write_idx,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next-state of the array: apply the pending write, keep entry 0 at zero
    // so writes to it are discarded without a separate enable path.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (write_idx != ADDR_W'(ZERO_REG))) begin
            regs_d[write_idx] = write_data;
        end
        regs_d[0] = '0;
    end

    // Storage: asynchronous clear, otherwise load next-state every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_rs (
        .regs    (regs_q),
        .rd_idx  (rs_idx),
        .wr_en   (RegWrite),
        .wr_idx  (write_idx),
        .wr_data (write_data),
        .rd_data (rs_data)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_rt (
        .regs    (regs_q),
        .rd_idx  (rt_idx),
        .wr_en   (RegWrite),
        .wr_idx  (write_idx),
        .wr_data (write_data),
        .rd_data (rt_data)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance without bypass, one with bypass, sharing
// stimulus. A plain array model predicts every read; literal checks pin it.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  write_idx;
    logic        RegWrite;
    logic [31:0] write_data;
    logic [31:0] rs_data_nb, rt_data_nb;
    logic [31:0] rs_data_by, rt_data_by;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_on    = 1'b0;

    logic [31:0] mdl [32];

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
        .clk        (clk),
        .rst        (rst),
        .rs_idx     (rs_idx),
        .rt_idx     (rt_idx),
        .write_idx  (write_idx),
        .RegWrite   (RegWrite),
        .write_data (write_data),
        .rs_data    (rs_data_nb),
        .rt_data    (rt_data_nb)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_by (
        .clk        (clk),
        .rst        (rst),
        .rs_idx     (rs_idx),
        .rt_idx     (rt_idx),
        .write_idx  (write_idx),
        .RegWrite   (RegWrite),
        .write_data (write_data),
        .rs_data    (rs_data_by),
        .rt_data    (rt_data_by)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    endtask

    // Model read: stored value, overridden by a pending write only with bypass,
    // and register 0 always zero.
    function automatic logic [31:0] mdl_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && RegWrite && write_idx == idx) return write_data;
        return mdl[idx];
    endfunction

    // Model state update: clear on reset, commit writes on the rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (RegWrite && write_idx != 5'd0) begin
            mdl[write_idx] = write_data;
        end
    end

    // Per-cycle compare of all four read ports against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_rs_nb", rs_data_nb, mdl_rd(rs_idx, 1'b0));
            chk("cyc_rt_nb", rt_data_nb, mdl_rd(rt_idx, 1'b0));
            chk("cyc_rs_by", rs_data_by, mdl_rd(rs_idx, 1'b1));
            chk("cyc_rt_by", rt_data_by, mdl_rd(rt_idx, 1'b1));
        end
    end

    task automatic drive(input bit we, input logic [4:0] widx, input logic [31:0] wd,
                         input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        RegWrite   = we;
        write_idx  = widx;
        write_data = wd;
        rs_idx     = a;
        rt_idx     = b;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b1; RegWrite = 1'b0; write_idx = '0; write_data = '0;
        rs_idx = 5'd5; rt_idx = 5'd31;
        #2;
        chk("rst_hold_rs5",  rs_data_nb, 32'h0);
        chk("rst_hold_rt31", rt_data_by, 32'h0);
        // Pending write while reset is held must be ignored.
        RegWrite = 1'b1; write_idx = 5'd5; write_data = 32'hCAFE_0001;
        #20;
        RegWrite = 1'b0;
        #1 rst = 1'b0;
        cmp_on = 1'b1;

        for (int k = 0; k < 3; k++) begin
            logic [4:0] tbl [3];
            tbl = '{5'd0, 5'd5, 5'd31};
            drive(1'b0, 5'd0, 32'h0, tbl[k], tbl[k]);
            at_neg();
            chk("rst_rd_rs_nb", rs_data_nb, 32'h0);
            chk("rst_rd_rt_by", rt_data_by, 32'h0);
        end

        drive(1'b1, 5'd5, 32'h0000_0042, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        at_neg();
        chk("wr5_rs", rs_data_nb, 32'h0000_0042);

        drive(1'b1, 5'd10, 32'h1234_5678, 5'd5, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd5);
        at_neg();
        chk("wr10_rs", rs_data_nb, 32'h1234_5678);
        chk("wr10_rt", rt_data_by, 32'h0000_0042);

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        at_neg();
        chk("zero_byp_rs", rs_data_by, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        at_neg();
        chk("zero_rs", rs_data_nb, 32'h0);

        drive(1'b0, 5'd10, 32'hDEAD_BEEF, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        at_neg();
        chk("en_off_rs", rs_data_nb, 32'h1234_5678);

        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        at_neg();
        chk("byp1_pre",  rs_data_by, 32'hA5A5_A5A5);
        chk("byp0_pre",  rs_data_nb, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        at_neg();
        chk("byp0_post", rs_data_nb, 32'hA5A5_A5A5);

        drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        at_neg();
        chk("ones_rt31", rt_data_nb, 32'hFFFF_FFFF);

        // Model-only traffic: back-to-back writes with reads of neighbours.
        for (int k = 1; k < 32; k++) begin
            drive(1'b1, 5'(k), 32'h9E37_79B9 * k, 5'(k), 5'(k - 1));
        end
        for (int k = 0; k < 8; k++) begin
            drive(k[0], 5'(3 * k), ~(32'h1000 << k), 5'(3 * k + 1), 5'(3 * k));
        end

        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        at_neg();
        chk("pre_arst_rs10", rs_data_nb, 32'h9E37_79B9 * 10);
        #1 rst = 1'b1;
        #1;
        chk("arst_rs_nb", rs_data_nb, 32'h0);
        chk("arst_rs_by", rs_data_by, 32'h0);
        #1 rst = 1'b0;
        drive(1'b1, 5'd12, 32'h0BAD_F00D, 5'd12, 5'd10);
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd10);
        at_neg();
        chk("post_arst_rs12", rs_data_nb, 32'h0BAD_F00D);
        chk("post_arst_rt10", rt_data_nb, 32'h0);

        @(posedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, got %0d expected finish", $time);
        $fatal(1);
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the single-cycle/pipelined MIPS-style datapath.
- 32 registers of 32 bits, two combinational read ports (rs, rt) and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (source index fields) and the ALU/writeback path.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, index width; register count is 2**ADDR_W = 32.
- BYPASS, 0, read-during-write behaviour on the same edge:
  - 0: a read returns the stored value.
  - 1: a read returns write_data when a write to the same non-zero index is pending in that cycle.

Ports:
- clk  in  1  system clock; all writes on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears all registers.
- rs_idx  in  ADDR_W  read port A index.
- rt_idx  in  ADDR_W  read port B index.
- write_idx  in  ADDR_W  write port index.
- RegWrite  in  1  write enable, sampled on the rising clk edge.
- write_data  in  DATA_W  data to write.
- rs_data  out  DATA_W  contents of register rs_idx (combinational).
- rt_data  out  DATA_W  contents of register rt_idx (combinational).

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-high (rst). While rst=1, all 32 registers are held at 0 immediately, independent of clk.
  - Outputs therefore read 0 during reset.
  - Reset released mid-cycle: no write occurs until the next rising edge where rst=0.
- Write:
  - On a rising edge with rst=0 and RegWrite=1 and write_idx != 0: reg[write_idx] <= write_data.
  - Latency is 1 edge; the new value is visible on the read ports right after that edge.
  - RegWrite=0: no register changes.
  - write_idx=0: the write is silently discarded; reg[0] stays 0 permanently.
  - Any write_data pattern is accepted, including all-ones.
- Read:
  - Purely combinational, zero-cycle latency.
  - rs_data = reg[rs_idx] and rt_data = reg[rt_idx].
  - Index 0 always returns 32'h0000_0000.
  - Both ports are independent and may address the same register simultaneously.
- Read during write, same cycle and same index:
  - BYPASS=0: the port shows the old value until the edge, then the new value.
  - BYPASS=1: the port shows write_data combinationally whenever RegWrite=1, write_idx == port index and index != 0.
  - Bypass never applies to index 0.
- No X propagation: every register has a defined reset value; outputs are never X after the first reset.
- No handshake or back-pressure; the write completes unconditionally in one cycle.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W and ADDR_W constants.
  - ZERO_REG index constant (5'd0).
  - Typedefs for reg_idx_t [ADDR_W-1:0] and word_t [DATA_W-1:0].
- One natural sub-module: reg_file_rd_port, instantiated twice (rs, rt).
  - Function: index mux + zero-register override + optional bypass compare.
- The storage array and write logic stay in reg_file.

Test Plan:
- Reset: hold rst=1, then drop it; read indices 0, 5, 31 on both ports -> all read 32'h0000_0000.
- Basic write/read: RegWrite=1, write_idx=5, write_data=32'h0000_0042, one edge; RegWrite=0, rs_idx=5 -> rs_data=32'h0000_0042.
- Second register: write 32'h1234_5678 to reg[10]; rs_idx=10, rt_idx=5 -> rs_data=32'h1234_5678, rt_data=32'h0000_0042, with reg[5] unaffected.
- Zero register: RegWrite=1, write_idx=0, write_data=32'hFFFF_FFFF, one edge; rs_idx=0 -> rs_data=32'h0000_0000.
- Enable off: RegWrite=0, write_idx=10, write_data=32'hDEAD_BEEF, one edge -> reg[10] still 32'h1234_5678.
- Async reset mid-run plus same-cycle read:
  - Assert rst between edges -> rs_data for reg[10] drops to 0 before the next edge.
  - BYPASS=1, write reg[7]=32'hA5A5_A5A5 with rs_idx=7 -> rs_data=32'hA5A5_A5A5 before the edge.
  - BYPASS=0, same stimulus -> rs_data changes only after the edge.
